esp_uart: RTL and testbench

Memory-mapped serial link between the aq32 CPU and the ESP32 co-processor. It is the CPU-side responder for the two-register ESP interface at 0x2000/0x2004 that boot and runtime software poll. It buffers CPU command bytes in a TX FIFO and serialises them onto the ESP UART line. It also deserialises ESP replies into an RX FIFO for the CPU to drain.

---
 rtl/esp_uart.sv | 188 ++++++++++++++++++
 tb/tb_esp_uart.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/esp_uart.sv
// esp_uart: CPU-side STATUS/DATA responder with TX/RX FIFOs and an 11-bit
// framed UART (start, 8 data LSB first, SOF flag, stop) to the ESP32.
module esp_uart_fifo #(
  parameter int AW = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push,
  input  logic [8:0] din,
  input  logic       pop,
  output logic [8:0] dout,
  output logic       empty,
  output logic       full
);
  logic [8:0]  mem_q [2**AW];
  logic [AW:0] wp_q, rp_q;
  assign empty = wp_q == rp_q;
  assign full  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign dout  = mem_q[rp_q[AW-1:0]];
  always_ff @(posedge clk)
    if (push && !full) mem_q[wp_q[AW-1:0]] <= din;
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      if (push && !full) wp_q <= wp_q + 1'b1;
      if (pop && !empty) rp_q <= rp_q + 1'b1;
    end
endmodule

module esp_uart #(
  parameter int BAUD_DIV        = 14,
  parameter int FIFO_DEPTH_LOG2 = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        bus_addr,
  input  logic [31:0] bus_wrdata,
  input  logic        bus_wren,
  input  logic        bus_rden,
  output logic [31:0] bus_rddata,
  input  logic        uart_rxd,
  output logic        uart_txd
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam logic [BW-1:0] BMAX  = BW'(BAUD_DIV - 1);
  localparam logic [BW-1:0] BHALF = BW'(BAUD_DIV / 2 - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_FLAG, S_STOP} state_t;

  logic [8:0]  tx_head, rx_head;
  logic        tx_empty, tx_full, rx_empty, rx_full;
  logic        tx_push, tx_pop, rx_push, rx_pop, st_wr;
  state_t      tx_state_q, tx_state_d, rx_state_q, rx_state_d;
  logic [BW-1:0] tx_baud_q, tx_baud_d, rx_baud_q, rx_baud_d;
  logic [2:0]  tx_bit_q, tx_bit_d, rx_bit_q, rx_bit_d;
  logic [8:0]  tx_sh_q, tx_sh_d, rx_sh_q, rx_sh_d;
  logic [1:0]  sync_q;
  logic        prev_q, ovf_q, ovf_d, ferr_q, ferr_d, ferr_set;
  logic [31:0] rddata_q, rddata_d;
  logic        tx_tick, rx_tick, rxs, unused_bits;

  assign unused_bits = ^bus_wrdata[31:9];
  assign tx_push = bus_wren & bus_addr;
  assign st_wr   = bus_wren & ~bus_addr;
  assign rx_pop  = bus_rden & bus_addr & ~rx_empty;
  assign tx_tick = tx_baud_q == '0;
  assign rx_tick = rx_baud_q == '0;
  assign rxs     = sync_q[1];
  assign bus_rddata = rddata_q;
  // Driven straight from async-reset state so reset forces the line idle at once
  assign uart_txd = (tx_state_q == S_START) ? 1'b0 :
                    (tx_state_q == S_DATA || tx_state_q == S_FLAG) ? tx_sh_q[0] : 1'b1;

  esp_uart_fifo #(.AW(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clk(clk), .reset(reset), .push(tx_push), .din(bus_wrdata[8:0]), .pop(tx_pop),
    .dout(tx_head), .empty(tx_empty), .full(tx_full)
  );
  esp_uart_fifo #(.AW(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clk(clk), .reset(reset), .push(rx_push), .din(rx_sh_q), .pop(rx_pop),
    .dout(rx_head), .empty(rx_empty), .full(rx_full)
  );

  always_comb begin
    tx_state_d = tx_state_q;
    tx_baud_d  = (tx_state_q == S_IDLE) ? tx_baud_q : tx_tick ? BMAX : tx_baud_q - 1'b1;
    tx_bit_d   = tx_bit_q;
    tx_sh_d    = tx_sh_q;
    tx_pop     = 1'b0;
    case (tx_state_q)
      S_IDLE: if (!tx_empty) begin
        tx_pop     = 1'b1;
        tx_sh_d    = tx_head;
        tx_baud_d  = BMAX;
        tx_state_d = S_START;
      end
      S_START: if (tx_tick) begin
        tx_state_d = S_DATA;
        tx_bit_d   = '0;
      end
      S_DATA: if (tx_tick) begin
        tx_sh_d    = {1'b0, tx_sh_q[8:1]};
        tx_bit_d   = tx_bit_q + 3'd1;
        tx_state_d = (tx_bit_q == 3'd7) ? S_FLAG : S_DATA;
      end
      S_FLAG: if (tx_tick) tx_state_d = S_STOP;
      // Chain straight into the next start bit when more bytes are queued
      S_STOP: if (tx_tick) begin
        tx_pop     = !tx_empty;
        tx_sh_d    = tx_empty ? tx_sh_q : tx_head;
        tx_state_d = tx_empty ? S_IDLE : S_START;
      end
      default: tx_state_d = S_IDLE;
    endcase
  end

  always_comb begin
    rx_state_d = rx_state_q;
    rx_baud_d  = (rx_state_q == S_IDLE) ? rx_baud_q : rx_tick ? BMAX : rx_baud_q - 1'b1;
    rx_bit_d   = rx_bit_q;
    rx_sh_d    = rx_sh_q;
    rx_push    = 1'b0;
    ferr_set   = 1'b0;
    case (rx_state_q)
      S_IDLE: if (prev_q && !rxs) begin
        rx_state_d = S_START;
        rx_baud_d  = BHALF;
      end
      S_START: if (rx_tick) begin
        rx_state_d = rxs ? S_IDLE : S_DATA;
        rx_bit_d   = '0;
      end
      S_DATA: if (rx_tick) begin
        rx_sh_d    = {rxs, rx_sh_q[8:1]};
        rx_bit_d   = rx_bit_q + 3'd1;
        rx_state_d = (rx_bit_q == 3'd7) ? S_FLAG : S_DATA;
      end
      S_FLAG: if (rx_tick) begin
        rx_sh_d    = {rxs, rx_sh_q[8:1]};
        rx_state_d = S_STOP;
      end
      S_STOP: if (rx_tick) begin
        rx_push    = rxs;
        ferr_set   = !rxs;
        rx_state_d = S_IDLE;
      end
      default: rx_state_d = S_IDLE;
    endcase
  end

  assign ovf_d  = (rx_push & rx_full) | (ovf_q & ~(st_wr & bus_wrdata[2]));
  assign ferr_d = ferr_set | (ferr_q & ~(st_wr & bus_wrdata[3]));
  assign rddata_d = !bus_rden ? rddata_q :
                    bus_addr  ? {23'b0, rx_empty ? 9'b0 : rx_head} :
                                {28'b0, ferr_q, ovf_q, tx_full, ~rx_empty};

  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      tx_state_q <= S_IDLE;
      tx_baud_q  <= '0;
      tx_bit_q   <= '0;
      tx_sh_q    <= '0;
      rx_state_q <= S_IDLE;
      rx_baud_q  <= '0;
      rx_bit_q   <= '0;
      rx_sh_q    <= '0;
      sync_q     <= 2'b11;
      prev_q     <= 1'b1;
      ovf_q      <= 1'b0;
      ferr_q     <= 1'b0;
      rddata_q   <= '0;
    end else begin
      tx_state_q <= tx_state_d;
      tx_baud_q  <= tx_baud_d;
      tx_bit_q   <= tx_bit_d;
      tx_sh_q    <= tx_sh_d;
      rx_state_q <= rx_state_d;
      rx_baud_q  <= rx_baud_d;
      rx_bit_q   <= rx_bit_d;
      rx_sh_q    <= rx_sh_d;
      sync_q     <= {sync_q[0], uart_rxd};
      prev_q     <= sync_q[1];
      ovf_q      <= ovf_d;
      ferr_q     <= ferr_d;
      rddata_q   <= rddata_d;
    end
endmodule

// File: tb/tb_esp_uart.sv
// tb_esp_uart: scoreboard bench for esp_uart; expected TX frames and RX words
// are queued as stimulus is driven and compared as the DUT produces them.
module tb_esp_uart;
  localparam int BD = 14;
  logic        clk = 0, reset = 1, bus_addr = 0, bus_wren = 0, bus_rden = 0, uart_rxd = 1;
  logic [31:0] bus_wrdata = 0;
  logic [31:0] bus_rddata;
  logic        uart_txd;
  int errors = 0, checks = 0, cyc = 0, frames = 0, last_start = 0;
  bit mon_en = 1;
  logic [8:0] tx_q[$], rx_q[$];

  esp_uart #(.BAUD_DIV(BD), .FIFO_DEPTH_LOG2(4)) dut (
    .clk(clk), .reset(reset), .bus_addr(bus_addr), .bus_wrdata(bus_wrdata),
    .bus_wren(bus_wren), .bus_rden(bus_rden), .bus_rddata(bus_rddata),
    .uart_rxd(uart_rxd), .uart_txd(uart_txd)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic wr(input logic a, input logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_wrdata = d; bus_wren = 1;
    @(negedge clk);
    bus_wren = 0;
  endtask

  task automatic rd(input logic a, output logic [31:0] d);
    @(negedge clk);
    bus_addr = a; bus_rden = 1;
    @(negedge clk);
    bus_rden = 0;
    d = bus_rddata;
  endtask

  task automatic rd_chk(input logic a, input string tag, input logic [31:0] exp);
    logic [31:0] v;
    rd(a, v);
    check(tag, v, exp);
  endtask

  task automatic rd_data(input string tag);
    logic [31:0] v, e;
    e = (rx_q.size() != 0) ? {23'b0, rx_q.pop_front()} : 32'h0;
    rd(1'b1, v);
    check(tag, v, e);
  endtask

  task automatic rx_frame(input logic [7:0] b, input logic f, input logic stop);
    logic [10:0] fr;
    fr = {stop, f, b, 1'b0};
    @(negedge clk);
    for (int i = 0; i < 11; i++) begin
      uart_rxd = fr[i];
      repeat (BD) @(negedge clk);
    end
    uart_rxd = 1;
    if (stop && rx_q.size() < 16) rx_q.push_back({f, b});
    repeat (4) @(negedge clk);
  endtask

  task automatic drain(input string tag);
    int n;
    n = 0;
    while (tx_q.size() != 0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, tx_q.size(), 0);
    repeat (10) @(negedge clk);
  endtask

  // TX line monitor: decodes each frame at bit centres
  initial begin : tx_mon
    logic [9:0] w;
    logic s0;
    logic [31:0] e;
    int st;
    forever begin
      @(negedge clk);
      if (mon_en && !reset && uart_txd === 1'b0) begin
        st = cyc;
        frames++;
        if (frames >= 3) check("tx_b2b_gap", st - last_start, 11 * BD);
        last_start = st;
        repeat (BD / 2) @(negedge clk);
        s0 = uart_txd;
        for (int i = 0; i < 10; i++) begin
          repeat (BD) @(negedge clk);
          w[i] = uart_txd;
        end
        if (mon_en) begin
          e = (tx_q.size() != 0) ? {23'b0, tx_q.pop_front()} : 32'hdead;
          check("tx_startbit", s0, 0);
          check("tx_word", {23'b0, w[8:0]}, e);
          check("tx_stopbit", w[9], 1);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [8:0] w;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_rddata", bus_rddata, 0);
    reset = 0;
    rd_chk(0, "status_reset", 0);
    // single frame and start latency
    wr(1, 32'h10); tx_q.push_back(9'h010);
    check("tx_idle_before_start", uart_txd, 1);
    @(negedge clk);
    check("tx_start_latency", uart_txd, 0);
    drain("tx_drain1");
    // flag frame then a burst queued behind it
    wr(1, 32'h100); tx_q.push_back(9'h100);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 16; i++) begin
      w = 9'(i * 37 + 5);
      wr(1, {23'b0, w}); tx_q.push_back(w);
    end
    rd_chk(0, "tx_full_status", 2);
    wr(1, 32'h1AB);
    rd_chk(0, "tx_full_after_drop", 2);
    drain("tx_drain_burst");
    check("tx_frame_count", frames, 18);
    rd_chk(0, "status_tx_idle", 0);
    // single RX frame
    rx_frame(8'h5A, 1, 1);
    rd_chk(0, "rx_status_ne", 1);
    rd_data("rx_data");
    rd_chk(0, "rx_status_empty", 0);
    rd_data("rx_data_empty");
    // RX overflow
    for (int i = 0; i < 17; i++) rx_frame(8'(i * 29 + 3), i[0], 1);
    rd_chk(0, "rx_ovf_status", 5);
    for (int i = 0; i < 16; i++) rd_data("rx_ovf_data");
    rd_chk(0, "rx_ovf_sticky", 4);
    wr(0, 32'h4);
    rd_chk(0, "rx_ovf_clear", 0);
    // framing error, then glitch, then recovery
    rx_frame(8'hC3, 0, 0);
    rd_chk(0, "rx_ferr_status", 8);
    rd_data("rx_ferr_nopush");
    wr(0, 32'h8);
    rd_chk(0, "rx_ferr_clear", 0);
    @(negedge clk); uart_rxd = 0;
    repeat (2) @(negedge clk); uart_rxd = 1;
    repeat (30) @(negedge clk);
    rd_chk(0, "rx_glitch_ignored", 0);
    rx_frame(8'h81, 0, 1);
    rd_data("rx_after_errors");
    // reset in the middle of both frames
    mon_en = 0;
    wr(1, 32'h000);
    repeat (40) @(negedge clk);
    check("tx_mid_frame_low", uart_txd, 0);
    fork
      rx_frame(8'h00, 0, 1);
      begin
        repeat (60) @(negedge clk);
        #1 reset = 1;
        #1 check("rst_txd_async", uart_txd, 1);
      end
    join
    rx_q.delete();
    tx_q.delete();
    repeat (3) @(negedge clk);
    reset = 0;
    repeat (5) @(negedge clk);
    rd_chk(0, "status_after_reset", 0);
    rd_data("rx_no_stray_word");
    repeat (20) @(negedge clk);
    check("txd_idle_after_reset", uart_txd, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
